// File: rtl/seg7_disp_sched_pkg.sv
// +------------------------------------------------------------------+
// | seg7_sched_pkg : shared types/constants for the display scheduler |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package seg7_sched_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK  = 7'h00;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

`default_nettype wire

// File: rtl/seg7_disp_sched_if.sv
// +------------------------------------------------------------------+
// | seg7_disp_sched_if : requester, control and display signal group |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface seg7_disp_sched_if;
  logic       iREQ_A;
  logic [2:0] iADDR_A;
  logic [6:0] iDATA_A;
  logic       oACK_A;
  logic       iREQ_B;
  logic [2:0] iADDR_B;
  logic [6:0] iDATA_B;
  logic       oACK_B;
  logic       iCLR;
  logic [7:0] iBLINK_MASK;
  logic       oSCAN_TICK;
  logic [6:0] oSEG0, oSEG1, oSEG2, oSEG3, oSEG4, oSEG5, oSEG6, oSEG7;

  modport master (
    output iREQ_A, iADDR_A, iDATA_A, iREQ_B, iADDR_B, iDATA_B, iCLR, iBLINK_MASK,
    input  oACK_A, oACK_B, oSCAN_TICK,
    input  oSEG0, oSEG1, oSEG2, oSEG3, oSEG4, oSEG5, oSEG6, oSEG7
  );

  modport slave (
    input  iREQ_A, iADDR_A, iDATA_A, iREQ_B, iADDR_B, iDATA_B, iCLR, iBLINK_MASK,
    output oACK_A, oACK_B, oSCAN_TICK,
    output oSEG0, oSEG1, oSEG2, oSEG3, oSEG4, oSEG5, oSEG6, oSEG7
  );
endinterface

`default_nettype wire

// File: rtl/seg7_disp_sched_tick_gen.sv
// +------------------------------------------------------------------+
// | seg7_tick_gen : scan-rate prescaler plus frame/blink phase timer  |
// | Blink timing built only with SEG7_SCHED_BLINK_EN.   Rev 1.0       |
// +------------------------------------------------------------------+
`default_nettype none

module seg7_tick_gen #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  wire logic iCLK,
  input  wire logic nRST,
  output logic      oSCAN_TICK,
  output logic      oPHASE
);

  localparam logic [15:0] c_div_max = 16'(SCAN_DIV - 1);

  logic [15:0] presc_q;
  logic        tick_q;
  logic        w_wrap;

  assign w_wrap = (presc_q == c_div_max);

  always_ff @(posedge iCLK) begin
    if (nRST) begin
      presc_q <= 16'd0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= w_wrap ? 16'd0 : presc_q + 16'd1;
      tick_q  <= w_wrap;
    end
  end

  assign oSCAN_TICK = tick_q;

`ifdef SEG7_SCHED_BLINK_EN
  localparam logic [9:0] c_frm_max = 10'(BLINK_FRAMES - 1);

  logic [2:0] tcnt_q;
  logic [9:0] frm_q;
  logic       phase_q;

  // A frame ends on the wrap that takes the tick counter past 7.
  always_ff @(posedge iCLK) begin
    if (nRST) begin
      tcnt_q  <= 3'd0;
      frm_q   <= 10'd0;
      phase_q <= 1'b0;
    end else if (w_wrap) begin
      tcnt_q <= tcnt_q + 3'd1;
      if (tcnt_q == 3'd7) begin
        if (frm_q == c_frm_max) begin
          frm_q   <= 10'd0;
          phase_q <= ~phase_q;
        end else begin
          frm_q <= frm_q + 10'd1;
        end
      end
    end
  end

  assign oPHASE = phase_q;
`else
  assign oPHASE = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/seg7_disp_sched.sv
// +------------------------------------------------------------------+
// | seg7_disp_sched : round-robin digit writer + scan tick + blinking |
// | Blink overlay built only with SEG7_SCHED_BLINK_EN.  Rev 1.0        |
// +------------------------------------------------------------------+
`default_nettype none

module seg7_disp_sched
  import seg7_sched_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  wire logic         iCLK,
  input  wire logic         nRST,
  seg7_disp_sched_if.slave  bus
);

  state_e     state_q, state_d;
  req_id_e    last_q, last_d;
  req_id_e    w_win;
  logic       ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic       w_we;
  logic [2:0] w_addr;
  logic [6:0] w_data;
  logic       w_phase;
  logic [6:0] digit_q [NUM_DIGITS];
  logic [6:0] w_seg   [NUM_DIGITS];

  always_ff @(posedge iCLK) begin
    if (nRST) begin
      state_q <= IDLE;
      last_q  <= REQ_B;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
    end
  end

  // Grants only from IDLE, so at most one write every two cycles.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    w_win   = REQ_A;
    w_we    = 1'b0;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    w_addr  = bus.iADDR_A;
    w_data  = bus.iDATA_A;
    case (state_q)
      IDLE: begin
        if (!bus.iCLR && (bus.iREQ_A || bus.iREQ_B)) begin
          if (bus.iREQ_A && bus.iREQ_B)
            w_win = (last_q == REQ_A) ? REQ_B : REQ_A;
          else
            w_win = bus.iREQ_A ? REQ_A : REQ_B;
          w_we    = 1'b1;
          last_d  = w_win;
          state_d = ACK;
          ack_a_d = (w_win == REQ_A);
          ack_b_d = (w_win == REQ_B);
          if (w_win == REQ_B) begin
            w_addr = bus.iADDR_B;
            w_data = bus.iDATA_B;
          end
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (nRST || bus.iCLR) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= SEG_BLANK;
    end else if (w_we) begin
      digit_q[w_addr] <= w_data;
    end
  end

  seg7_tick_gen #(
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_tick_gen (
    .iCLK       (iCLK),
    .nRST       (nRST),
    .oSCAN_TICK (bus.oSCAN_TICK),
    .oPHASE     (w_phase)
  );

  for (genvar n = 0; n < NUM_DIGITS; n++) begin : g_seg
`ifdef SEG7_SCHED_BLINK_EN
    assign w_seg[n] = (bus.iBLINK_MASK[n] && w_phase) ? SEG_BLANK : digit_q[n];
`else
    assign w_seg[n] = digit_q[n];
`endif
  end

`ifndef SEG7_SCHED_BLINK_EN
  logic w_unused_blink;
  assign w_unused_blink = w_phase ^ (^bus.iBLINK_MASK);
`endif

  assign bus.oACK_A = ack_a_q;
  assign bus.oACK_B = ack_b_q;
  assign bus.oSEG0  = w_seg[0];
  assign bus.oSEG1  = w_seg[1];
  assign bus.oSEG2  = w_seg[2];
  assign bus.oSEG3  = w_seg[3];
  assign bus.oSEG4  = w_seg[4];
  assign bus.oSEG5  = w_seg[5];
  assign bus.oSEG6  = w_seg[6];
  assign bus.oSEG7  = w_seg[7];

endmodule

`default_nettype wire

// File: doc/seg7_disp_sched.md
# seg7_disp_sched

Display scheduler and arbiter for the 8-digit multiplexed 7-segment display. It holds the 8-entry digit register file that drives the scanner's eight 7-bit digit inputs. Two independent requesters (A and B) write into it through a round-robin req/ack handshake. The block also generates the scan-rate tick and an optional per-digit blink overlay.

## Interface
Parameters:
- SCAN_DIV, 1000: iCLK cycles per scan tick (digit dwell); legal range 2..65535.
- BLINK_FRAMES, 64: frames (1 frame = 8 scan ticks) per blink half-period; legal range 1..1023.

Ports:
- iCLK  in  1  clock.
- nRST  in  1  reset, synchronous, active-high.
- iREQ_A  in  1  requester A write request.
- iADDR_A  in  3  digit index 0..7.
- iDATA_A  in  7  segment pattern, active-high, bit0=a … bit6=g.
- oACK_A  out  1  one-cycle write acknowledge to A.
- iREQ_B, iADDR_B, iDATA_B, oACK_B: same as A, for requester B.
- iCLR  in  1  clears all digits to 7'h00.
- iBLINK_MASK  in  8  bit n = digit n blinks.
- oSCAN_TICK  out  1  one-cycle pulse every SCAN_DIV cycles.
- oSEG0..oSEG7  out  7 each  digit patterns presented to the scanner.

## Operation
- FSM states: IDLE, ACK.
- IDLE, iCLR=1:
  - All 8 digit registers are set to 0.
  - No grant; stay in IDLE. Pending requests stay pending.
- IDLE, iCLR=0, at least one request high:
  - Select the winner. If only one request is high, it wins. If both are high, the requester not served last wins (pointer LAST).
  - Write DATA into digit[ADDR] at the clock edge.
  - Set the winner's oACK to 1 and LAST to the winner; go to ACK.
- ACK:
  - Both oACKs are 0 on exit. No grant, even if requests are high. iCLR is still honoured.
  - Go to IDLE.
- Handshake rule: the requester holds REQ/ADDR/DATA stable until it sees oACK=1. In the ACK cycle it may drop REQ or present the next request. A REQ still high after ACK is treated as a new write.
- Throughput: at most one write per 2 cycles. A continuously requesting pair alternates A,B,A,B.
- Tick generator:
  - A 16-bit prescaler counts 0..SCAN_DIV-1 and wraps to 0.
  - oSCAN_TICK is registered high for one cycle when the prescaler wraps.
  - A 3-bit tick counter defines frames.
  - A frame counter toggles PHASE after BLINK_FRAMES frames, then wraps to 0.
- Output: oSEGn = (BLINK_EN and iBLINK_MASK[n] and PHASE) ? 7'h00 : digit[n]. This path is combinational from registers.
- Reset values:
  - All digits 0.
  - oACK_A = oACK_B = 0.
  - State IDLE; LAST = B, so A wins the first tie.
  - Prescaler, tick counter and frame counter 0.
  - PHASE = 0 (visible); oSCAN_TICK = 0.
  - All oSEGn = 0.
- Reset mid-handshake: any ACK in flight is dropped (oACK = 0 next cycle). The write already committed stays discarded, because reset clears the digits.

## Timing
- Request first high in IDLE cycle N:
  - digit[ADDR] updated at the end of N.
  - oSEGn shows the new value in N+1.
  - oACK high in N+1 only.
- iCLR in cycle N: all oSEGn = 0 in N+1. A request made during N is granted no earlier than N+1.
- First oSCAN_TICK occurs SCAN_DIV cycles after reset deasserts, then every SCAN_DIV cycles.
- PHASE toggles every 8·SCAN_DIV·BLINK_FRAMES cycles.
- Changes to iBLINK_MASK take effect combinationally, in the same cycle.

## Configuration
- SEG7_SCHED_BLINK_EN defined: the frame counter, PHASE and the blink overlay are built.
- Not defined: that logic is removed, iBLINK_MASK is ignored, and oSEGn = digit[n]. The prescaler and oSCAN_TICK are always present.

## Structure
- Package seg7_sched_pkg holds:
  - the FSM state enum (IDLE, ACK);
  - NUM_DIGITS = 8;
  - SEG_BLANK = 7'h00;
  - the requester id encoding (REQ_A = 0, REQ_B = 1).
- Sub-module seg7_tick_gen contains the prescaler, tick counter and frame/PHASE counter, and outputs oSCAN_TICK and PHASE. The arbiter FSM and digit register file stay in the top.

## Test plan
- Reset, then A writes addr 3, data 7'h3F → oACK_A pulses 1 cycle after REQ; oSEG3 = 7'h3F; other digits 0.
- A and B request together (A→addr0 7'h06, B→addr1 7'h5B), both held high → A acked first, B acked 2 cycles later; oSEG0 = 7'h06, oSEG1 = 7'h5B.
- iCLR asserted in the same cycle as B's request → all oSEGn = 0, no ACK that cycle; B acked 2 cycles later with its data written.
- SCAN_DIV = 4 → oSCAN_TICK high at cycles 4, 8, 12… after reset release, width 1.
- With blink enabled: SCAN_DIV = 2, BLINK_FRAMES = 1, iBLINK_MASK = 8'h01, digit0 = 7'h7F → oSEG0 alternates 7'h7F / 0 every 16 cycles; oSEG1 unaffected.
- nRST asserted during the ACK cycle → oACK = 0 and all digits 0 next cycle; FSM in IDLE.
